free_list: RTL and testbench

Physical-register free list for the rename stage, directly upstream of the reorder buffer. It hands out free physical registers to renaming instructions and takes back the old mapping of each retiring instruction. On a rewind it reclaims the registers of squashed instructions by walking its allocation pointer backwards, so a squash restores the exact pre-allocation state. Storage is a circular buffer of `PHY_REGS-ARC_REGS` entries with head, tail and occupancy count.

---
 rtl/free_list_pkg.sv | 29 ++
 rtl/free_list_if.sv | 32 +++
 rtl/free_list.sv | 116 +++++++++++
 tb/tb_free_list.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/free_list_pkg.sv
// Shared rename-stage types and sizing for the physical-register free list.
// Index helpers wrap explicitly because the list depth need not be a power of two.
package free_list_pkg;

   localparam int PHY_REGS     = 64;
   localparam int ARC_REGS     = 32;
   localparam int RENAME_WIDTH = 2;
   localparam int RETIRE_WIDTH = 2;
   localparam int REWIND_WIDTH = 2;

   localparam int PW       = $clog2(PHY_REGS);
   localparam int AW       = $clog2(ARC_REGS);
   localparam int FL_DEPTH = PHY_REGS - ARC_REGS;
   localparam int IW       = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;

   typedef logic [PW-1:0] phy_reg_t;
   typedef logic [AW-1:0] arc_reg_t;
   typedef logic [IW-1:0] fl_idx_t;
   typedef logic [PW:0]   fl_cnt_t;

   function automatic fl_idx_t idx_inc(input fl_idx_t idx);
      return (idx == fl_idx_t'(FL_DEPTH - 1)) ? '0 : fl_idx_t'(idx + 1'b1);
   endfunction

   function automatic fl_idx_t idx_dec(input fl_idx_t idx);
      return (idx == '0) ? fl_idx_t'(FL_DEPTH - 1) : fl_idx_t'(idx - 1'b1);
   endfunction

endpackage

// File: rtl/free_list_if.sv
// Rename/retire/rewind bundle between the pipeline (master) and the free list (slave).
interface free_list_if;
   import free_list_pkg::*;

   logic     [RENAME_WIDTH-1:0] alloc_req;
   logic     [RENAME_WIDTH-1:0] alloc_gnt;
   phy_reg_t [RENAME_WIDTH-1:0] alloc_phy;

   logic     [RETIRE_WIDTH-1:0] retire_valid;
   arc_reg_t [RETIRE_WIDTH-1:0] retire_arc_dst;
   phy_reg_t [RETIRE_WIDTH-1:0] retire_phy_dst_old;

   logic     [REWIND_WIDTH-1:0] rewind_valid;
   arc_reg_t [REWIND_WIDTH-1:0] rewind_arc_dst;
   phy_reg_t [REWIND_WIDTH-1:0] rewind_phy_dst;

   fl_cnt_t                     free_count;
   logic                        error;

   modport master (
      output alloc_req, retire_valid, retire_arc_dst, retire_phy_dst_old,
             rewind_valid, rewind_arc_dst, rewind_phy_dst,
      input  alloc_gnt, alloc_phy, free_count, error
   );

   modport slave (
      input  alloc_req, retire_valid, retire_arc_dst, retire_phy_dst_old,
             rewind_valid, rewind_arc_dst, rewind_phy_dst,
      output alloc_gnt, alloc_phy, free_count, error
   );

endinterface

// File: rtl/free_list.sv
// Circular-buffer free list of physical registers: in-order grants from head,
// retire refills at tail, rewind walks head backwards to undo squashed grants.
module free_list
   import free_list_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   free_list_if.slave  fl
);

   phy_reg_t r_entry [FL_DEPTH];
   fl_idx_t  r_head;
   fl_idx_t  r_tail;
   fl_cnt_t  r_count;
   logic     r_error;

   phy_reg_t                    w_entry_nxt [FL_DEPTH];
   fl_idx_t                     w_head_nxt;
   fl_idx_t                     w_tail_nxt;
   fl_cnt_t                     w_count_nxt;
   logic                        w_error_nxt;
   logic     [RENAME_WIDTH-1:0] w_gnt;
   phy_reg_t [RENAME_WIDTH-1:0] w_phy;

   int      w_grants;
   int      w_frees;
   int      w_total;
   logic    w_blocked;
   fl_idx_t w_hptr;
   fl_idx_t w_tptr;

   // NOTE: combinational blocks use blocking (=) so the running pointers and
   // counters below are read back in the same pass; every output gets a default
   // first so no latch is inferred.
   always_comb begin
      w_entry_nxt = r_entry;
      w_error_nxt = r_error;
      w_gnt       = '0;
      w_phy       = '0;
      w_grants    = 0;
      w_frees     = 0;
      w_hptr      = r_head;
      w_tptr      = r_tail;
      w_blocked   = |fl.rewind_valid;

      // Grants stay in order: the first unserved request blocks all younger slots.
      for (int i = 0; i < RENAME_WIDTH; i++) begin
         if (fl.alloc_req[i] && !w_blocked && (w_grants < int'(r_count))) begin
            w_gnt[i] = 1'b1;
            w_phy[i] = r_entry[w_hptr];
            w_hptr   = idx_inc(w_hptr);
            w_grants = w_grants + 1;
         end else if (fl.alloc_req[i]) begin
            w_blocked = 1'b1;
         end
      end

      // Rewind slots arrive youngest first, so each one un-pops the previous head slot.
      for (int i = 0; i < REWIND_WIDTH; i++) begin
         if (fl.rewind_valid[i] && (fl.rewind_arc_dst[i] != '0)) begin
            w_hptr = idx_dec(w_hptr);
            if (r_entry[w_hptr] != fl.rewind_phy_dst[i]) begin
               w_error_nxt = 1'b1;
            end
            w_frees = w_frees + 1;
         end
      end
      w_head_nxt = w_hptr;

      for (int i = 0; i < RETIRE_WIDTH; i++) begin
         if (fl.retire_valid[i] && (fl.retire_arc_dst[i] != '0)) begin
            w_entry_nxt[w_tptr] = fl.retire_phy_dst_old[i];
            w_tptr              = idx_inc(w_tptr);
            w_frees             = w_frees + 1;
         end
      end
      w_tail_nxt = w_tptr;

      w_total = int'(r_count) - w_grants + w_frees;
      if (w_total > FL_DEPTH) begin
         w_error_nxt = 1'b1;
         w_count_nxt = fl_cnt_t'(FL_DEPTH);
      end else if (w_total < 0) begin
         w_error_nxt = 1'b1;
         w_count_nxt = '0;
      end else begin
         w_count_nxt = fl_cnt_t'(w_total);
      end
   end

   // NOTE: the storage array is reset too, because its initial contents
   // (ARC_REGS+i) are the registers handed out right after reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FL_DEPTH; i++) begin
            r_entry[i] <= phy_reg_t'(ARC_REGS + i);
         end
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= fl_cnt_t'(FL_DEPTH);
         r_error <= 1'b0;
      end else begin
         r_entry <= w_entry_nxt;
         r_head  <= w_head_nxt;
         r_tail  <= w_tail_nxt;
         r_count <= w_count_nxt;
         r_error <= w_error_nxt;
      end
   end

   assign fl.alloc_gnt  = w_gnt;
   assign fl.alloc_phy  = w_phy;
   assign fl.free_count = r_count;
   assign fl.error      = r_error;

endmodule

// File: tb/tb_free_list.sv
// Randomized and directed bench for free_list; a queue/stack model predicts every
// cycle's grants, free_count and error, and a monitor compares against the DUT.
module tb_free_list;
   import free_list_pkg::*;

   typedef struct {
      logic [1:0] req;
      logic [1:0] ret_v;
      int         ret_arc [2];
      int         ret_phy [2];
      logic [1:0] rew_v;
      int         rew_arc [2];
      int         rew_phy [2];
   } stim_t;

   typedef struct {
      logic [1:0] gnt;
      int         phy0;
      int         phy1;
      int         cnt;
      bit         err;
   } exp_t;

   logic clock;
   logic reset;

   free_list_if fl_if ();

   free_list dut (
      .clock (clock),
      .reset (reset),
      .fl    (fl_if)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_cmp  = 0;
   int n_fail = 0;

   exp_t sb_q [$];
   int   free_q [$];
   int   stk [$];
   bit   m_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      free_q.delete();
      stk.delete();
      for (int i = 0; i < FL_DEPTH; i++) free_q.push_back(ARC_REGS + i);
      m_err = 1'b0;
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s.req   = '0;
      s.ret_v = '0;
      s.rew_v = '0;
      for (int k = 0; k < 2; k++) begin
         s.ret_arc[k] = 0; s.ret_phy[k] = 0;
         s.rew_arc[k] = 0; s.rew_phy[k] = 0;
      end
      return s;
   endfunction

   // Predicts the outputs visible this cycle, then advances the model across the edge.
   function automatic void model_step(input stim_t s);
      exp_t e;
      int   ng;
      int   v;
      bit   blocked;
      e.gnt  = '0;
      e.phy0 = 0;
      e.phy1 = 0;
      e.cnt  = free_q.size();
      e.err  = m_err;
      blocked = (s.rew_v != 0);
      ng = 0;
      for (int i = 0; i < 2; i++) begin
         if (s.req[i] && !blocked && ng < free_q.size()) begin
            e.gnt[i] = 1'b1;
            if (i == 0) e.phy0 = free_q[ng];
            else        e.phy1 = free_q[ng];
            ng++;
         end else if (s.req[i]) begin
            blocked = 1'b1;
         end
      end
      sb_q.push_back(e);

      repeat (ng) stk.push_back(free_q.pop_front());
      while (stk.size() > FL_DEPTH) void'(stk.pop_front());

      for (int i = 0; i < 2; i++) begin
         if (s.rew_v[i] && s.rew_arc[i] != 0) begin
            v = (stk.size() > 0) ? stk.pop_back() : -1;
            if (v != s.rew_phy[i]) m_err = 1'b1;
            if (free_q.size() < FL_DEPTH) free_q.push_front(v);
            else                          m_err = 1'b1;
         end
      end
      for (int i = 0; i < 2; i++) begin
         if (s.ret_v[i] && s.ret_arc[i] != 0) begin
            if (free_q.size() < FL_DEPTH) free_q.push_back(s.ret_phy[i]);
            else                          m_err = 1'b1;
         end
      end
   endfunction

   task automatic drive(input stim_t s);
      @(negedge clock);
      fl_if.alloc_req    = s.req;
      fl_if.retire_valid = s.ret_v;
      fl_if.rewind_valid = s.rew_v;
      for (int k = 0; k < 2; k++) begin
         fl_if.retire_arc_dst[k]     = arc_reg_t'(s.ret_arc[k]);
         fl_if.retire_phy_dst_old[k] = phy_reg_t'(s.ret_phy[k]);
         fl_if.rewind_arc_dst[k]     = arc_reg_t'(s.rew_arc[k]);
         fl_if.rewind_phy_dst[k]     = phy_reg_t'(s.rew_phy[k]);
      end
      model_step(s);
   endtask

   // Asserts reset between edges and checks the asynchronous clear before releasing it.
   task automatic do_reset();
      @(negedge clock);
      fl_if.retire_valid = '0;
      fl_if.rewind_valid = '0;
      fl_if.alloc_req    = 2'b11;
      #1 reset = 1'b0;
      #1;
      check("rst_gnt", fl_if.alloc_gnt, 2'b11);
      check("rst_phy0", fl_if.alloc_phy[0], ARC_REGS);
      check("rst_count", fl_if.free_count, FL_DEPTH);
      check("rst_error", fl_if.error, 0);
      #5 reset = 1'b1;
      model_reset();
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clock);
         #2;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("gnt", fl_if.alloc_gnt, e.gnt);
            if (e.gnt[0]) check("phy0", fl_if.alloc_phy[0], e.phy0);
            if (e.gnt[1]) check("phy1", fl_if.alloc_phy[1], e.phy1);
            check("free_count", fl_if.free_count, e.cnt);
            check("error", fl_if.error, e.err);
         end
      end
   end

   initial begin : stimulus
      stim_t s;
      int    room;
      int    nrew;
      fl_if.alloc_req = '0;
      fl_if.retire_valid = '0;
      fl_if.rewind_valid = '0;
      fl_if.retire_arc_dst = '0;
      fl_if.retire_phy_dst_old = '0;
      fl_if.rewind_arc_dst = '0;
      fl_if.rewind_phy_dst = '0;
      reset = 1'b0;
      model_reset();

      // First allocation after reset.
      do_reset();
      s = idle(); s.req = 2'b11; drive(s);
      #2;
      check("d1_phy0", fl_if.alloc_phy[0], 32);
      check("d1_phy1", fl_if.alloc_phy[1], 33);
      check("d1_count_before", fl_if.free_count, 32);
      drive(idle());
      #2 check("d1_count_after", fl_if.free_count, 30);

      // Drain, then a freed register is allocatable only on the next cycle.
      do_reset();
      repeat (16) begin s = idle(); s.req = 2'b11; drive(s); end
      s = idle(); s.req = 2'b11; drive(s);
      #2 check("d2_empty_gnt", fl_if.alloc_gnt, 0);
      s = idle(); s.req = 2'b11; s.ret_v = 2'b01; s.ret_arc[0] = 3; s.ret_phy[0] = 5; drive(s);
      #2 check("d2_same_cycle_gnt", fl_if.alloc_gnt, 0);
      s = idle(); s.req = 2'b11; drive(s);
      #2;
      check("d2_gnt", fl_if.alloc_gnt, 2'b01);
      check("d2_phy0", fl_if.alloc_phy[0], 5);

      // Rewind restores the exact pre-allocation order.
      do_reset();
      repeat (3) begin s = idle(); s.req = 2'b01; drive(s); end
      s = idle(); s.rew_v = 2'b11;
      s.rew_arc[0] = 4; s.rew_phy[0] = 34;
      s.rew_arc[1] = 6; s.rew_phy[1] = 33;
      drive(s);
      s = idle(); s.req = 2'b11; drive(s);
      #2;
      check("d3_phy0", fl_if.alloc_phy[0], 33);
      check("d3_phy1", fl_if.alloc_phy[1], 34);
      check("d3_error", fl_if.error, 0);

      // Head wrap: head at 31 grants entry 31 then entry 0.
      do_reset();
      repeat (15) begin s = idle(); s.req = 2'b11; drive(s); end
      s = idle(); s.req = 2'b01; drive(s);
      s = idle(); s.ret_v = 2'b11;
      s.ret_arc[0] = 1; s.ret_phy[0] = 7;
      s.ret_arc[1] = 2; s.ret_phy[1] = 8;
      drive(s);
      s = idle(); s.req = 2'b11; drive(s);
      #2;
      check("d4_phy0", fl_if.alloc_phy[0], 63);
      check("d4_phy1", fl_if.alloc_phy[1], 7);

      // Ignored retire (arc 0) alongside an effective rewind: count only +1.
      s = idle(); s.ret_v = 2'b01; s.ret_arc[0] = 0; s.ret_phy[0] = 9;
      s.rew_v = 2'b01; s.rew_arc[0] = 5; s.rew_phy[0] = 7;
      drive(s);
      drive(idle());
      #2;
      check("d5_count", fl_if.free_count, 2);
      check("d5_error", fl_if.error, 0);

      // Mismatching rewind sets a sticky error.
      s = idle(); s.rew_v = 2'b01; s.rew_arc[0] = 5; s.rew_phy[0] = 0; drive(s);
      repeat (3) drive(idle());
      #2 check("d6_error_sticky", fl_if.error, 1);
      do_reset();

      // Retire into a full list overflows.
      s = idle(); s.ret_v = 2'b01; s.ret_arc[0] = 1; s.ret_phy[0] = 3; drive(s);
      drive(idle());
      #2;
      check("d7_error", fl_if.error, 1);
      check("d7_count_sat", fl_if.free_count, 32);
      do_reset();

      // Random traffic kept inside the legal envelope.
      for (int c = 0; c < 600; c++) begin
         s = idle();
         room = FL_DEPTH - free_q.size();
         if ($urandom_range(0, 3) == 0) begin
            nrew = $urandom_range(0, 2);
            if (nrew > stk.size()) nrew = stk.size();
            if (nrew > room) nrew = room;
            for (int k = 0; k < nrew; k++) begin
               s.rew_v[k]   = 1'b1;
               s.rew_arc[k] = $urandom_range(1, ARC_REGS - 1);
               s.rew_phy[k] = stk[stk.size() - 1 - k];
            end
            room = room - nrew;
            if (nrew < 2 && $urandom_range(0, 3) == 0) begin
               s.rew_v[nrew]   = 1'b1;
               s.rew_arc[nrew] = 0;
               s.rew_phy[nrew] = $urandom_range(0, PHY_REGS - 1);
            end
         end
         s.req = 2'($urandom_range(0, 3));
         for (int k = 0; k < 2; k++) begin
            if ($urandom_range(0, 1) == 1) begin
               s.ret_v[k]   = 1'b1;
               s.ret_arc[k] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, ARC_REGS - 1);
               if (s.ret_arc[k] != 0) begin
                  if (room > 0) room--;
                  else          s.ret_arc[k] = 0;
               end
               s.ret_phy[k] = $urandom_range(0, PHY_REGS - 1);
            end
         end
         drive(s);
      end
      drive(idle());

      repeat (3) @(negedge clock);
      check("sb_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
